// File: rtl/pid_pwm_drive.sv
// Sign/magnitude PWM drive for a bridge, fed by the PID control word.
// Emits the controller sample strobe and forces one dark frame on every direction reversal.
module pid_pwm_drive #(
  parameter int PERIOD   = 1024,
  parameter int DEADBAND = 8,
  parameter int MAX_DUTY = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] control,
  input  logic        drive_en,
  output logic        pwm_out,
  output logic        dir,
  output logic        sample,
  output logic [15:0] duty,
  output logic        sat
);

  generate
    if (PERIOD < 4 || PERIOD > 65535 || MAX_DUTY > PERIOD || MAX_DUTY < 0) begin : g_bad_params
      $error("pid_pwm_drive: illegal PERIOD/MAX_DUTY combination");
    end
  endgenerate

  localparam logic [15:0] LAST = 16'(PERIOD - 1);
  localparam logic [15:0] PRE  = 16'(PERIOD - 2);
  localparam logic [15:0] DB   = 16'(DEADBAND);
  localparam logic [15:0] MAXD = 16'(MAX_DUTY);

  typedef enum logic [1:0] {IDLE, RUN, REVERSE} state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n, duty_n;
  logic        dir_n, sat_n;
  logic [15:0] mag, new_duty;
  logic        new_sat, new_dir;

  // -32768 has no positive 16-bit counterpart, so it saturates to 32767
  always_comb begin
    if (control == 16'h8000) mag = 16'h7fff;
    else if (control[15])    mag = ~control + 16'd1;
    else                     mag = control;
    new_dir  = control[15];
    new_sat  = 1'b0;
    new_duty = mag;
    if (mag <= DB) begin
      new_duty = '0;
    end else if (mag > MAXD) begin
      new_duty = MAXD;
      new_sat  = 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    duty_n  = duty;
    dir_n   = dir;
    sat_n   = sat;
    if (!drive_en) begin
      state_n = IDLE;
      cnt_n   = '0;
      duty_n  = '0;
      sat_n   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_n = RUN;
          cnt_n   = '0;
          duty_n  = '0;
          sat_n   = 1'b0;
        end
        RUN, REVERSE: begin
          if (cnt == LAST) begin
            cnt_n = '0;
            // a sign change with nonzero drive costs one dark frame, dir flips at its start
            if (new_duty != '0 && new_dir != dir) begin
              state_n = REVERSE;
              duty_n  = '0;
              sat_n   = 1'b0;
              dir_n   = new_dir;
            end else begin
              state_n = RUN;
              duty_n  = new_duty;
              sat_n   = new_sat;
              if (new_duty != '0) dir_n = new_dir;
            end
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          duty_n  = '0;
          sat_n   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      duty    <= '0;
      dir     <= 1'b0;
      sat     <= 1'b0;
      pwm_out <= 1'b0;
      sample  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      duty    <= duty_n;
      dir     <= dir_n;
      sat     <= sat_n;
      pwm_out <= (state_n == RUN) && (cnt_n < duty_n);
      sample  <= (state_n != IDLE) && (cnt_n == PRE);
    end
  end

endmodule

// File: tb/tb_pid_pwm_drive.sv
// Bench for pid_pwm_drive: frame-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized control words.
module tb_pid_pwm_drive;

  localparam int P  = 1024;
  localparam int DB = 8;
  localparam int MD = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        drive_en;
  logic [15:0] control;
  logic        pwm_out, dir, sample, sat;
  logic [15:0] duty;

  pid_pwm_drive #(.PERIOD(P), .DEADBAND(DB), .MAX_DUTY(MD)) dut (
    .clk(clk), .reset(reset), .control(control), .drive_en(drive_en),
    .pwm_out(pwm_out), .dir(dir), .sample(sample), .duty(duty), .sat(sat)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  // model: is the drive on, where in the frame are we, what applies to this frame
  bit m_on, m_dark, m_dir, m_sat;
  int m_pos, m_duty;

  int f_high, f_samp, f_spos, f_duty, f_dir, f_sat;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_latch(input logic [15:0] c);
    int cv, mag, nd;
    bit ns, nneg;
    cv   = int'($signed(c));
    mag  = (cv < 0) ? -cv : cv;
    if (mag > 32767) mag = 32767;
    nneg = (cv < 0);
    ns   = 1'b0;
    if (mag <= DB)      nd = 0;
    else if (mag > MD) begin nd = MD; ns = 1'b1; end
    else                nd = mag;
    if (nd > 0 && nneg != m_dir) begin
      m_dark = 1'b1; m_duty = 0; m_sat = 1'b0; m_dir = nneg;
    end else begin
      m_dark = 1'b0; m_duty = nd; m_sat = ns;
      if (nd > 0) m_dir = nneg;
    end
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_on = 0; m_dark = 0; m_dir = 0; m_sat = 0; m_pos = 0; m_duty = 0;
    end else if (!drive_en) begin
      m_on = 0; m_dark = 0; m_sat = 0; m_pos = 0; m_duty = 0;
    end else if (!m_on) begin
      m_on = 1; m_dark = 0; m_sat = 0; m_pos = 0; m_duty = 0;
    end else if (m_pos == P - 1) begin
      m_pos = 0;
      model_latch(control);
    end else begin
      m_pos = m_pos + 1;
    end
  end

  always @(negedge clk) begin
    if (check_en && !reset) begin
      chk("pwm_out", int'(pwm_out), int'(m_on && !m_dark && (m_pos < m_duty)));
      chk("sample",  int'(sample),  int'(m_on && (m_pos == P - 2)));
      chk("duty",    int'(duty),    m_duty);
      chk("dir",     int'(dir),     int'(m_dir));
      chk("sat",     int'(sat),     int'(m_sat));
    end
  end

  task automatic wait_start();
    int k = 0;
    while (!(m_on && m_pos == 0) && k < 2 * P + 8) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2 * P + 8) begin
      n_cmp++; n_bad++;
      $display("FAIL frame_start: no frame start within %0d cycles", k);
    end
  endtask

  // one full frame from its first cycle; control switches to c1 at position chg
  task automatic frame(input logic [15:0] c0, input logic [15:0] c1, input int chg);
    wait_start();
    control = c0;
    f_high = 0; f_samp = 0; f_spos = -1;
    f_duty = int'(duty); f_dir = int'(dir); f_sat = int'(sat);
    for (int i = 0; i < P; i++) begin
      if (i == chg) control = c1;
      if (pwm_out) f_high++;
      if (sample) begin f_samp++; f_spos = i; end
      @(negedge clk);
    end
  endtask

  function automatic logic [15:0] rnd_ctl();
    int v;
    case ($urandom_range(0, 5))
      0: v = int'($urandom_range(0, 12));
      1: v = int'($urandom_range(0, 1200));
      2: return 16'h8000;
      3: return 16'h7fff;
      4: return 16'($urandom);
      default: v = int'($urandom_range(990, 1010));
    endcase
    if ($urandom_range(0, 1) == 1) v = -v;
    return 16'(v);
  endfunction

  initial begin
    int prev_dir;
    logic [15:0] c;
    reset = 1'b1; drive_en = 1'b0; control = '0;
    #1;
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_duty", int'(duty), 0);
    chk("rst_sample", int'(sample), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_en = 1'b1;
    @(negedge clk);
    drive_en = 1'b1; control = 16'd500;

    frame(16'd500, 16'd500, -1);
    chk("first_frame_high", f_high, 0);
    chk("first_frame_samples", f_samp, 1);
    chk("first_sample_pos", f_spos, P - 2);
    frame(16'd5, 16'd5, -1);
    chk("p500_high", f_high, 500);
    chk("p500_duty", f_duty, 500);
    chk("p500_dir", f_dir, 0);
    chk("p500_samples", f_samp, 1);

    frame(-16'sd8, -16'sd8, -1);
    chk("db5_high", f_high, 0);
    frame(16'd9, 16'd9, -1);
    chk("dbm8_high", f_high, 0);
    chk("dbm8_dir", f_dir, 0);
    frame(16'd2000, 16'd2000, -1);
    chk("db9_duty", f_duty, 9);
    chk("db9_high", f_high, 9);

    frame(16'h8000, 16'h8000, -1);
    chk("p2000_duty", f_duty, 1000);
    chk("p2000_sat", f_sat, 1);
    frame(16'h8000, 16'h8000, -1);
    chk("rev_high", f_high, 0);
    chk("rev_dir", f_dir, 1);
    frame(16'd300, 16'd300, -1);
    chk("m32768_high", f_high, 1000);
    chk("m32768_sat", f_sat, 1);
    chk("m32768_dir", f_dir, 1);

    prev_dir = f_dir;
    for (int t = 0; t < 6; t++) begin
      frame((t % 2 == 0) ? -16'sd300 : 16'd300, (t % 2 == 0) ? -16'sd300 : 16'd300, -1);
      if (f_dir != prev_dir) chk("toggle_dark", f_high, 0);
      prev_dir = f_dir;
    end

    frame(16'd100, 16'd100, -1);
    frame(16'd100, 16'd100, -1);
    frame(16'd100, 16'd700, 50);
    chk("mid_old_high", f_high, 100);
    frame(16'd700, 16'd700, -1);
    chk("mid_new_high", f_high, 700);

    wait_start();
    repeat (300) @(negedge clk);
    chk("pre_off_pwm", int'(pwm_out), 1);
    drive_en = 1'b0;
    @(negedge clk);
    chk("off_pwm", int'(pwm_out), 0);
    chk("off_duty", int'(duty), 0);
    chk("off_dir", int'(dir), 0);
    repeat (5) @(negedge clk);
    drive_en = 1'b1; control = -16'sd700;
    frame(-16'sd700, -16'sd700, -1);
    chk("reen_high", f_high, 0);
    frame(-16'sd700, -16'sd700, -1);
    chk("reen_rev_high", f_high, 0);
    chk("reen_rev_dir", f_dir, 1);
    wait_start();
    repeat (300) @(negedge clk);
    chk("pre_rst_pwm", int'(pwm_out), 1);
    chk("pre_rst_dir", int'(dir), 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_pwm", int'(pwm_out), 0);
    chk("arst_duty", int'(duty), 0);
    chk("arst_dir", int'(dir), 0);
    chk("arst_sat", int'(sat), 0);
    @(negedge clk);
    reset = 1'b0;
    frame(-16'sd700, -16'sd700, -1);
    chk("post_rst_high", f_high, 0);

    prev_dir = int'(dir);
    for (int r = 0; r < 18; r++) begin
      if ($urandom_range(0, 5) == 0) begin
        wait_start();
        repeat ($urandom_range(1, P - 1)) @(negedge clk);
        drive_en = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        drive_en = 1'b1;
        wait_start();
        prev_dir = int'(dir);
      end else begin
        c = rnd_ctl();
        frame(c, ($urandom_range(0, 2) == 0) ? rnd_ctl() : c, int'($urandom_range(1, P - 3)));
        if (f_dir != prev_dir) chk("rnd_rev_dark", f_high, 0);
        chk("rnd_samples", f_samp, 1);
        prev_dir = f_dir;
      end
    end

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
